// File: rtl/main_control_fsm.sv
// Multicycle datapath main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives all datapath strobes combinationally from the current state.
module main_control_fsm #(
  parameter bit TRAP_EN = 1'b1
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [5:0] opCode,
  input  logic       memReady,
  output logic [1:0] aluOp,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] pcSource,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memToReg,
  output logic       regDst,
  output logic       regWrite,
  output logic       illegalOp,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRwb    = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11,
    StTrap   = 4'd12
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  state_e state_q, state_d;
  state_e out_st;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  state_d = memReady ? StDecode : StFetch;
      StDecode: begin
        if (opCode == OpRType) begin
          state_d = StExec;
        end else if (opCode == OpLw || opCode == OpSw) begin
          state_d = StMemAdr;
        end else if (opCode == OpBeq) begin
          state_d = StBranch;
        end else if (opCode == OpJ) begin
          state_d = StJump;
        end else if (opCode == OpAddi) begin
          state_d = StAddiEx;
        end else begin
          state_d = TRAP_EN ? StTrap : StFetch;
        end
      end
      StMemAdr: state_d = (opCode == OpLw) ? StMemRd : StMemWr;
      StMemRd:  state_d = memReady ? StMemWb : StMemRd;
      StMemWb:  state_d = StFetch;
      StMemWr:  state_d = memReady ? StFetch : StMemWr;
      StExec:   state_d = StRwb;
      StRwb:    state_d = StFetch;
      StBranch: state_d = StFetch;
      StJump:   state_d = StFetch;
      StAddiEx: state_d = StAddiWb;
      StAddiWb: state_d = StFetch;
      StTrap:   state_d = StTrap;
      default:  state_d = StFetch;
    endcase
  end

  // In reset the outputs show FETCH values with every write strobe suppressed.
  always_comb begin
    out_st      = resetN ? state_q : StFetch;
    aluOp       = 2'b00;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    pcSource    = 2'b00;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    memToReg    = 1'b0;
    regDst      = 1'b0;
    regWrite    = 1'b0;
    illegalOp   = 1'b0;
    case (out_st)
      StFetch: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        irWrite = memReady;
        pcWrite = memReady;
      end
      StDecode: aluSrcB = 2'b11;
      StMemAdr: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      StMemRd: begin
        memRead = 1'b1;
        iorD    = 1'b1;
      end
      StMemWb: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
      end
      StMemWr: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
      end
      StExec: begin
        aluSrcA = 1'b1;
        aluOp   = 2'b10;
      end
      StRwb: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
      end
      StBranch: begin
        aluSrcA     = 1'b1;
        aluOp       = 2'b01;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
      end
      StJump: begin
        pcWrite  = 1'b1;
        pcSource = 2'b10;
      end
      StAddiEx: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        aluOp   = 2'b11;
      end
      StAddiWb: regWrite = 1'b1;
      StTrap:   illegalOp = 1'b1;
      default:  ;
    endcase
    if (!resetN) begin
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      memWrite    = 1'b0;
      regWrite    = 1'b0;
      irWrite     = 1'b0;
    end
  end

  assign state = state_q;

endmodule
